// File: rtl/mix_columns_engine_if.sv
// Handshake and data bus of the MixColumns engine: an input channel
// (state + mode) and an output channel (transformed state).
interface mix_columns_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    // Producer/consumer side that talks to the engine.
    modport master (
        output in_valid, in_state, in_mode, out_ready,
        input  in_ready, out_valid, out_state
    );

    // The engine itself.
    modport slave (
        input  in_valid, in_state, in_mode, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine. A 128-bit state is accepted,
// transformed COLS_PER_CYCLE columns per clock in place in a work register,
// and the finished state is presented on the output until consumed.
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    mix_columns_engine_if.slave  bus,
    output logic                 busy
);
    localparam int STAGES = 4 / COLS_PER_CYCLE;
    localparam int CNT_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STAGES - 1);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic [127:0]     r_work;
    logic [127:0]     r_out;
    logic             r_out_valid;
    logic             r_busy;
    logic [127:0]     w_next_work;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the circulant matrix (02 03 01 01) or (0e 0b 0d 09).
    // Each byte's four coefficient products are built from its x2/x4/x8 chain;
    // row r then takes product k0 of byte r, k1 of byte r+1, and so on.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  a, x2, x4, x8;
        logic [7:0]  k0 [4];
        logic [7:0]  k1 [4];
        logic [7:0]  k2 [4];
        logic [7:0]  k3 [4];
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            a  = col[31-8*i -: 8];
            x2 = xtime(a);
            x4 = xtime(x2);
            x8 = xtime(x4);
            if (!inv) begin
                k0[i] = x2;
                k1[i] = x2 ^ a;
                k2[i] = a;
                k3[i] = a;
            end else begin
                k0[i] = x8 ^ x4 ^ x2;
                k1[i] = x8 ^ x2 ^ a;
                k2[i] = x8 ^ x4 ^ a;
                k3[i] = x8 ^ a;
            end
        end
        res = '0;
        for (int r = 0; r < 4; r++) begin
            res[31-8*r -: 8] = k0[2'(r)] ^ k1[2'(r + 1)] ^ k2[2'(r + 2)] ^ k3[2'(r + 3)];
        end
        return res;
    endfunction

    // Work register with the current column group replaced by its transform.
    always_comb begin
        // NOTE: default assignment before the loop keeps every bit driven on every path, so no latch is inferred.
        w_next_work = r_work;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            w_next_work[127-32*(int'(r_cnt)*COLS_PER_CYCLE + k) -: 32] =
                mix_col(r_work[127-32*(int'(r_cnt)*COLS_PER_CYCLE + k) -: 32], r_mode);
        end
    end

    // Control FSM with registered outputs; flush has priority over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            // NOTE: the work register is reset too; an unreset datapath flop in an async-reset block turns reset into a hidden enable.
            r_work      <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_work  <= bus.in_state;
                        r_mode  <= bus.in_mode;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_work <= w_next_work;
                    if (r_cnt == LAST_CNT) begin
                        r_out       <= w_next_work;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE) && !flush;
    assign bus.out_valid = r_out_valid;
    assign bus.out_state = r_out;
    assign busy          = r_busy;
endmodule

// File: tb/tb_mix_columns_engine.sv
// Testbench for mix_columns_engine: three instances (1, 2 and 4 columns per
// cycle). Expected values come from fixed vectors and from a reference model
// built on generic GF(2^8) multiplication and the MixColumns matrix.
module tb_mix_columns_engine;
    logic clk;
    logic rst_n;
    logic flush;
    logic flush_off;
    logic busy1, busy2, busy4;
    int   checks;
    int   errors;

    mix_columns_engine_if b1 ();
    mix_columns_engine_if b2 ();
    mix_columns_engine_if b4 ();

    mix_columns_engine #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .flush(flush_off), .bus(b1), .busy(busy1));
    mix_columns_engine #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .flush(flush),     .bus(b2), .busy(busy2));
    mix_columns_engine #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .flush(flush_off), .bus(b4), .busy(busy4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] st;
        logic         mode;
        logic [127:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Plain shift-and-add GF(2^8) multiply, polynomial 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // out[c][r] = XOR_j coef[(j - r) mod 4] * in[c][j]
    function automatic logic [127:0] ref_mix(input logic [127:0] st, input logic inv);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] res = '0;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(coef[(j - r + 4) % 4], st[127-32*c-8*j -: 8]);
                end
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [127:0] st, input logic m);
        case (sel)
            1:       begin b1.in_valid = v; b1.in_state = st; b1.in_mode = m; end
            4:       begin b4.in_valid = v; b4.in_state = st; b4.in_mode = m; end
            default: begin b2.in_valid = v; b2.in_state = st; b2.in_mode = m; end
        endcase
    endtask

    function automatic logic get_ov(input int sel);
        case (sel)
            1:       return b1.out_valid;
            4:       return b4.out_valid;
            default: return b2.out_valid;
        endcase
    endfunction

    function automatic logic [127:0] get_os(input int sel);
        case (sel)
            1:       return b1.out_state;
            4:       return b4.out_state;
            default: return b2.out_state;
        endcase
    endfunction

    // One transaction on an idle instance; lat counts edges after the accept edge.
    // in_mode/in_state are scrambled right after accept to show they are latched.
    task automatic run(input int sel, input logic [127:0] st, input logic m,
                       output logic [127:0] res, output int lat);
        @(negedge clk);
        drive(sel, 1'b1, st, m);
        @(posedge clk); #1;
        drive(sel, 1'b0, ~st, ~m);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (get_ov(sel)) break;
        end
        res = get_os(sel);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [6];
        logic [127:0] res, res2, st, cap, prev;
        int           lat, lat2, wait_cnt;

        checks = 0;
        errors = 0;
        vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        vecs[1] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
        vecs[2] = '{128'hd4d4d4d5_00000000_00000000_00000000, 1'b0, 128'hd5d5d7d6_00000000_00000000_00000000};
        vecs[3] = '{128'h01010101_d4bf5d30_c6c6c6c6_d4d4d4d5, 1'b0, 128'h01010101_046681e5_c6c6c6c6_d5d5d7d6};
        vecs[4] = '{128'h00000000_00000000_00000000_046681e5, 1'b1, 128'h00000000_00000000_00000000_d4bf5d30};
        vecs[5] = '{128'h0, 1'b1, 128'h0};

        rst_n = 1'b0;
        flush = 1'b0;
        flush_off = 1'b0;
        for (int s = 1; s <= 4; s *= 2) drive(s, 1'b0, 128'h0, 1'b0);
        b1.out_ready = 1'b1;
        b2.out_ready = 1'b1;
        b4.out_ready = 1'b1;

        // Reset state.
        #12;
        check("rst_out_valid", b2.out_valid, 1'b0);
        check("rst_busy", busy2, 1'b0);
        check("rst_out_state", b2.out_state, 128'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", b2.in_ready, 1'b1);
        check("rst_in_ready4", b4.in_ready, 1'b1);

        // Fixed vectors on the two-columns-per-cycle instance.
        for (int i = 0; i < 6; i++) begin
            run(2, vecs[i].st, vecs[i].mode, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'd2);
            check($sformatf("vec%0d_hold_idle", i), b2.out_state, vecs[i].exp);
        end

        // One column per cycle, forward.
        run(1, vecs[0].st, 1'b0, res, lat);
        check("c1_fwd_result", res, vecs[0].exp);
        check("c1_fwd_latency", 128'(lat), 128'd4);

        // Four columns per cycle, inverse.
        run(4, vecs[1].st, 1'b1, res, lat);
        check("c4_inv_result", res, vecs[1].exp);
        check("c4_inv_latency", 128'(lat), 128'd1);

        // Random round trips.
        for (int i = 0; i < 1000; i++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            run(2, st, 1'b0, res, lat);
            check("rt_fwd_result", res, ref_mix(st, 1'b0));
            check("rt_fwd_latency", 128'(lat), 128'd2);
            run(2, res, 1'b1, res2, lat2);
            check("rt_inv_result", res2, st);
            check("rt_inv_latency", 128'(lat2), 128'd2);
        end

        // Backpressure: result held for 10 cycles, new input ignored meanwhile.
        @(negedge clk);
        b2.out_ready = 1'b0;
        drive(2, 1'b1, vecs[3].st, 1'b0);
        @(posedge clk); #1;
        drive(2, 1'b1, vecs[1].st, 1'b1);
        wait_cnt = 0;
        while (!b2.out_valid && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check("bp_first_valid", b2.out_valid, 1'b1);
        cap = b2.out_state;
        check("bp_first_result", cap, vecs[3].exp);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", b2.out_valid, 1'b1);
            check("bp_hold_state", b2.out_state, cap);
            check("bp_hold_in_ready", b2.in_ready, 1'b0);
            check("bp_hold_busy", busy2, 1'b1);
        end
        @(negedge clk);
        b2.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", b2.out_valid, 1'b0);
        check("bp_release_in_ready", b2.in_ready, 1'b1);
        check("bp_release_busy", busy2, 1'b0);
        @(posedge clk); #1;
        check("bp_second_accept", busy2, 1'b1);
        drive(2, 1'b0, 128'h0, 1'b0);
        @(posedge clk); #1;
        check("bp_second_not_yet", b2.out_valid, 1'b0);
        @(posedge clk); #1;
        check("bp_second_valid", b2.out_valid, 1'b1);
        check("bp_second_result", b2.out_state, vecs[1].exp);
        @(posedge clk); #1;

        // Flush mid-BUSY with in_valid still high.
        prev = b2.out_state;
        @(negedge clk);
        drive(2, 1'b1, vecs[0].st, 1'b0);
        @(posedge clk); #1;
        check("fl_busy", busy2, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        drive(2, 1'b1, vecs[3].st, 1'b0);
        #1;
        check("fl_in_ready", b2.in_ready, 1'b0);
        @(posedge clk); #1;
        check("fl_idle_busy", busy2, 1'b0);
        check("fl_idle_valid", b2.out_valid, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        drive(2, 1'b0, 128'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("fl_no_valid", b2.out_valid, 1'b0);
            check("fl_no_busy", busy2, 1'b0);
        end
        check("fl_out_state_kept", b2.out_state, prev);

        // Reset pulse mid-BUSY, then a fresh transaction.
        @(negedge clk);
        drive(2, 1'b1, vecs[0].st, 1'b0);
        @(posedge clk); #1;
        drive(2, 1'b0, 128'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", b2.out_valid, 1'b0);
        check("mr_busy", busy2, 1'b0);
        check("mr_out_state", b2.out_state, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("mr_no_valid", b2.out_valid, 1'b0);
            check("mr_no_busy", busy2, 1'b0);
        end
        run(2, vecs[2].st, 1'b0, res, lat);
        check("mr_after_result", res, vecs[2].exp);
        check("mr_after_latency", 128'(lat), 128'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1: columns processed per clock; legal values 1, 2, 4; any other value is an elaboration error.
REQ-002 SHALL derive localparam STAGES = 4/COLS_PER_CYCLE: compute cycles per 128-bit state.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port flush, input, 1: synchronous abort; returns block to IDLE.
REQ-006 SHALL have port in_valid, input, 1: in_state and in_mode valid.
REQ-007 SHALL have port in_ready, output, 1: block can accept a state.
REQ-008 SHALL have port in_state, input, 128: AES state; column c = bits [127-32c -: 32]; row 0 = top byte of each column.
REQ-009 SHALL have port in_mode, input, 1: 0 = forward MixColumns (02,03,01,01); 1 = inverse (0e,0b,0d,09).
REQ-010 SHALL have port out_valid, output, 1: out_state holds a completed result.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts out_state.
REQ-012 SHALL have port out_state, output, 128: transformed state, same column/row layout as in_state.
REQ-013 SHALL have port busy, output, 1: high in BUSY or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE) && !flush.
REQ-015 SHALL accept when in_valid && in_ready: register in_state, latch in_mode, clear column counter, go BUSY.
REQ-016 SHALL in BUSY transform COLS_PER_CYCLE columns per cycle in ascending column order, writing results into the result register in place.
REQ-017 SHALL move BUSY->DONE on the cycle its last column group is written; out_valid asserts STAGES cycles after the accept edge (1, 2 or 4).
REQ-018 SHALL compute GF(2^8) products with polynomial 0x11B via xtime chains (x2, x4, x8 combinations); no 256-entry tables.
REQ-019 SHALL use the latched mode for the whole state; in_mode changes after accept have no effect.
REQ-020 SHALL hold out_state and out_valid stable in DONE until out_ready; DONE && out_ready -> IDLE next cycle, out_valid low.
REQ-021 SHALL not accept new input in BUSY or DONE (no overlap); in_valid held high is accepted on the first IDLE cycle.
REQ-022 SHALL hold out_state at its last value in IDLE (reset value until first result).
REQ-023 SHALL on flush (any state) go to IDLE next cycle, deassert out_valid, discard partial results; flush overrides in_valid and out_ready in the same cycle.
REQ-024 SHALL keep column counter width clog2(STAGES) (min 1 bit); counter wrap to 0 only via new accept.

Reset
REQ-025 SHALL on rst_n low, asynchronously: state=IDLE, column counter=0, out_valid=0, busy=0, out_state=128'h0, latched mode=0.
REQ-026 SHALL have in_ready=1 on the first edge after rst_n deasserts.
REQ-027 SHALL abandon any in-flight state on reset mid-operation with no output produced.

Verification
REQ-028 Forward, COLS_PER_CYCLE=1: columns db135345, f20a225c, 01010101, c6c6c6c6, mode 0 -> out_state 8e4da1bc 9fdc589d 01010101 c6c6c6c6, out_valid 4 cycles after accept.
REQ-029 Inverse, COLS_PER_CYCLE=4: input 8e4da1bc 9fdc589d 01010101 c6c6c6c6, mode 1 -> db135345 f20a225c 01010101 c6c6c6c6, out_valid 1 cycle after accept.
REQ-030 Round trip, COLS_PER_CYCLE=2: 1000 random states forward then inverse -> equals original; every latency = 2 cycles.
REQ-031 Backpressure: out_ready low 10 cycles -> out_state/out_valid stable, in_ready=0, in_valid ignored; out_ready high -> IDLE, next state accepted following cycle.
REQ-032 flush asserted mid-BUSY with in_valid high -> IDLE next cycle, out_valid never asserts, in_valid not accepted that cycle.
REQ-033 rst_n pulsed low mid-BUSY (between edges) -> out_valid, busy, out_state immediately 0; after release, column d4d4d4d5 mode 0 -> d5d5d7d6.
